led_sequencer_ctrl: RTL and testbench
=====================================

Name: led_sequencer_ctrl

Overview:
Controller that sequences the 8 board LEDs (D1–D8) through timed patterns on the 12 MHz iCE40 evaluation-kit clock. Requesters issue a command over a valid/ready handshake: a pattern mode and a step count. The block generates its own step tick, advances the pattern, and signals completion. It supports abort and continuous operation. It replaces free-running blink logic as the single owner of the LED pins.

Parameters:
TICK_DIV, 6000000, clk cycles per pattern step (default = 0.5 s at 12 MHz); legal range 2..2^DIV_W
DIV_W, 23, width of the tick divider counter; must satisfy 2^DIV_W >= TICK_DIV

Ports:
clk  in  1  system clock, 12 MHz
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_mode  in  2  0=OFF, 1=ALT, 2=CHASE, 3=BOUNCE
cmd_count  in  8  number of steps; 0 = run until abort
abort  in  1  stop the current run (level-sampled in RUN)
busy  out  1  high in RUN
done  out  1  one-cycle pulse at end of a command
tick  out  1  one-cycle pulse on each pattern step
led  out  8  LED drive, bit0 = D1

Behaviour:
- Clock and reset: single clock domain; clk; rst_n asynchronous active-low.
- Reset values: state=IDLE, cmd_ready=1, busy=0, done=0, tick=0, led=0x00, divider=0, remaining=0, dir=left.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid&&cmd_ready (cycle N).
  - Cycle N+1 initial pattern: OFF 0x00, ALT 0x55, CHASE 0x01, BOUNCE 0x01 with dir=left.
  - Latch mode; remaining=cmd_count; divider=0.
  - Next state: OFF goes to DONE (no ticks, done at N+1). Other modes go to RUN.
- RUN:
  - busy=1, cmd_ready=0; cmd_valid ignored.
  - Divider increments every cycle. When divider==TICK_DIV-1: divider wraps to 0 and tick=1 that cycle.
  - The pattern advances in the same edge as tick; led is registered, so the new value appears the cycle after the tick pulse.
  - First tick occurs TICK_DIV cycles after entering RUN.
- Pattern step rules:
  - ALT: led = ~led (0x55 <-> 0xAA).
  - CHASE: rotate left, 0x80 -> 0x01.
  - BOUNCE: shift in dir. At 0x80 with dir=left, flip to right and go to 0x40. At 0x01 with dir=right, flip to left and go to 0x02. Period 14 steps: 01,02,..,80,40,..,01,02.
- Step counting:
  - On each tick with latched count != 0: remaining decrements.
  - The tick that takes remaining 1->0 also performs the final advance and moves to DONE.
  - Count 0: never decrements; runs until abort.
- abort in RUN: next state DONE; led=0x00; divider cleared.
  - Abort and tick in the same cycle: abort wins; no advance, no tick output.
- DONE:
  - One cycle: done=1, busy=0, cmd_ready=0. Then IDLE.
  - led holds the final pattern (0x00 after OFF or abort) until the next accept.
- abort in IDLE or DONE: ignored.
- Reset mid-run: immediate return to reset values; no done pulse.
- Total run duration for count K: done is high exactly K*TICK_DIV+1 cycles after the accept cycle.

Optional Feature:
LED_ACTIVE_LOW_EN
- Defined: led output port = ~internal pattern (reset drives 0xFF; OFF/abort drive 0xFF). Internal state, tick, done and all timing are unchanged.
- Undefined: led is active-high as described above.

Test Plan:
(All with TICK_DIV=4.)
- Reset: assert rst_n=0 mid-cycle -> led=0x00, cmd_ready=1, busy=0, done=0 immediately (async).
- ALT, count=3: accept at N -> led=0x55 at N+1; ticks at N+4, N+8, N+12; led 0xAA, 0x55, 0xAA; done pulse at N+13; cmd_ready at N+14.
- CHASE, count=9: led steps 01,02,04,..,80,01,02 -> final led=0x02; exactly 9 tick pulses; one done pulse.
- BOUNCE, count=0: run 20 ticks -> sequence 02..80,40..01,02..40 with correct flips; then abort -> led=0x00, done next cycle, no further ticks.
- Abort coincident with the 2nd tick of CHASE -> no tick pulse that cycle, led=0x00, done 1 cycle later; cmd_valid held high during RUN is not accepted until IDLE.
- OFF mode: accept -> led=0x00, done at N+1, busy never asserted, zero ticks. Repeat with LED_ACTIVE_LOW_EN -> led=0xFF.

Source files
------------

// File: rtl/led_sequencer_ctrl.sv
`timescale 1ns/1ps
// led_sequencer_ctrl
// Owns the eight board LEDs (D1..D8, led[0] = D1) and steps them through
// OFF / ALT / CHASE / BOUNCE patterns on a self-generated step tick.
// Requesters hand over a mode and a step count on a valid/ready handshake.
// A count of 0 runs until abort. A done pulse marks the end of every command.
//
// Build option: define LED_ACTIVE_LOW_EN to drive the led port inverted
// (active-low LEDs). The internal pattern, tick, done and all timing are the
// same either way.
module led_sequencer_ctrl #(
  parameter int unsigned TICK_DIV = 6000000,
  parameter int unsigned DIV_W    = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_count,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       tick,
  output logic [7:0] led
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_OFF    = 2'd0,
    M_ALT    = 2'd1,
    M_CHASE  = 2'd2,
    M_BOUNCE = 2'd3
  } mode_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state;
  mode_t            mode_q;
  logic [DIV_W-1:0] divider;
  logic [7:0]       remaining;
  logic             dir_right;
  logic [7:0]       led_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             step_due;
  logic             tick_hit;
  logic [7:0]       next_led;
  logic             next_dir_right;

  // Step point: divider at its last value while running. An abort in the
  // same cycle suppresses both the tick pulse and the pattern advance.
  always_comb begin
    step_due = (state == S_RUN) && (divider == DIV_LAST);
    tick_hit = step_due && !abort;
  end

  // Next pattern value for the latched mode, applied only on a tick.
  always_comb begin
    next_led       = led_q;
    next_dir_right = dir_right;
    unique case (mode_q)
      M_ALT:   next_led = ~led_q;
      M_CHASE: next_led = {led_q[6:0], led_q[7]};
      M_BOUNCE: begin
        if (!dir_right) begin
          if (led_q == 8'h80) begin
            next_led       = 8'h40;
            next_dir_right = 1'b1;
          end else begin
            next_led = {led_q[6:0], 1'b0};
          end
        end else begin
          if (led_q == 8'h01) begin
            next_led       = 8'h02;
            next_dir_right = 1'b0;
          end else begin
            next_led = {1'b0, led_q[7:1]};
          end
        end
      end
      default: next_led = led_q;
    endcase
  end

  // Command FSM with registered handshake/status outputs and LED pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= M_OFF;
      divider   <= '0;
      remaining <= '0;
      dir_right <= 1'b0;
      led_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (cmd_valid && ready_q) begin
            mode_q    <= mode_t'(cmd_mode);
            remaining <= cmd_count;
            divider   <= '0;
            dir_right <= 1'b0;
            ready_q   <= 1'b0;
            unique case (mode_t'(cmd_mode))
              M_OFF: begin
                led_q  <= 8'h00;
                state  <= S_DONE;
                done_q <= 1'b1;
              end
              M_ALT: begin
                led_q  <= 8'h55;
                state  <= S_RUN;
                busy_q <= 1'b1;
              end
              M_CHASE, M_BOUNCE: begin
                led_q  <= 8'h01;
                state  <= S_RUN;
                busy_q <= 1'b1;
              end
              default: begin
                led_q  <= 8'h00;
                state  <= S_DONE;
                done_q <= 1'b1;
              end
            endcase
          end
        end

        S_RUN: begin
          if (abort) begin
            led_q   <= 8'h00;
            divider <= '0;
            state   <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (step_due) begin
            divider   <= '0;
            led_q     <= next_led;
            dir_right <= next_dir_right;
            // remaining == 0 while running means an unbounded (count 0) run
            if (remaining != 8'd0) begin
              remaining <= remaining - 8'd1;
              if (remaining == 8'd1) begin
                state  <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end else begin
            divider <= divider + DIV_W'(1);
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tick      = tick_hit;

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~led_q;
`else
  assign led = led_q;
`endif

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
`timescale 1ns/1ps
// tb_led_sequencer_ctrl
// Directed plus randomized commands against a cycle-indexed reference model
// of the LED sequencer (TICK_DIV = 4). Expected outputs are computed from the
// cycle offset since the accept edge and the pattern step number.
module tb_led_sequencer_ctrl;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_count = 8'd0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic       tick;
  logic [7:0] led;

  int unsigned checks = 0;
  int unsigned errors = 0;

  led_sequencer_ctrl #(
    .TICK_DIV (TD),
    .DIV_W    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_count (cmd_count),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .tick      (tick),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Physical LED value for a given logical pattern.
  function automatic logic [7:0] phys(input logic [7:0] p);
`ifdef LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  // Pattern after j steps from the initial value of a mode.
  function automatic logic [7:0] pat(input logic [1:0] m, input int unsigned j);
    int unsigned p;
    logic [7:0] one;
    one = 8'h01;
    case (m)
      2'd1: return (j % 2 == 0) ? 8'h55 : 8'hAA;
      2'd2: return one << (j % 8);
      2'd3: begin
        p = j % 14;
        return (p <= 7) ? (one << p) : (one << (14 - p));
      end
      default: return 8'h00;
    endcase
  endfunction

  // Issue one command and check every output on every cycle until back in
  // IDLE. ab = cycle (counted from the accept edge) with abort high, 0 = none.
  // hold keeps cmd_valid high (with a different command) through RUN and DONE.
  task automatic run(input logic [1:0] m, input logic [7:0] k,
                     input int unsigned ab, input bit hold);
    int unsigned endc;
    int unsigned nt;
    int unsigned exp_nt;
    bit aborted;
    logic [7:0] e_led;
    logic e_tick, e_busy, e_done, e_rdy;

    if (m == 2'd0) begin
      endc = 0; aborted = 0; exp_nt = 0;
    end else if (k != 0 && (ab == 0 || ab > TD * k)) begin
      endc = TD * k; aborted = 0; exp_nt = k;
    end else begin
      endc = ab; aborted = 1; exp_nt = (ab - 1) / TD;
    end
    nt = 0;

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_mode = m; cmd_count = k; abort = 1'b0;
    @(negedge clk);
    check("ready_before_accept", cmd_ready, 1'b1);
    check("busy_before_accept", busy, 1'b0);

    for (int unsigned c = 1; c <= endc + 2; c++) begin
      @(posedge clk); #1;
      cmd_valid = hold && (c <= endc + 1);
      cmd_mode  = 2'd1;
      cmd_count = 8'd1;
      abort     = (c == ab) || (hold && c == endc + 1);
      @(negedge clk);
      if (c <= endc) begin
        e_led = pat(m, (c - 1) / TD);
        e_tick = (c % TD == 0) && (c != ab);
        e_busy = 1'b1; e_done = 1'b0; e_rdy = 1'b0;
      end else if (c == endc + 1) begin
        e_led = (aborted || m == 2'd0) ? 8'h00 : pat(m, k);
        e_tick = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_rdy = 1'b0;
      end else begin
        e_led = (aborted || m == 2'd0) ? 8'h00 : pat(m, k);
        e_tick = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
      end
      if (tick === 1'b1) nt++;
      check("led", led, phys(e_led));
      check("tick", tick, e_tick);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("cmd_ready", cmd_ready, e_rdy);
    end
    check("tick_count", 8'(nt), 8'(exp_nt));
    cmd_valid = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [1:0] rm;
    logic [7:0] rk;
    int unsigned rab;
    bit rh;

    // Asynchronous reset asserted mid-cycle, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_led", led, phys(8'h00));
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tick", tick, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed cases
    run(2'd1, 8'd3, 0, 1'b0);          // ALT x3: done at N+13
    run(2'd2, 8'd9, 0, 1'b0);          // CHASE x9: ends on 0x02
    run(2'd3, 8'd0, TD * 20 + 2, 1'b0); // BOUNCE forever, abort after 20 ticks
    run(2'd2, 8'd0, TD * 2, 1'b1);     // abort on 2nd CHASE tick, valid held
    run(2'd0, 8'd5, 0, 1'b0);          // OFF: done at N+1
    run(2'd1, 8'd1, 0, 1'b1);          // single step, abort in DONE ignored
    run(2'd3, 8'd15, 0, 1'b0);         // BOUNCE wrap past one period

    // Randomized commands
    for (int r = 0; r < 14; r++) begin
      rm = 2'($urandom_range(0, 3));
      rk = 8'($urandom_range(0, 10));
      if (rm == 2'd0) rab = 0;
      else if (rk == 8'd0) rab = $urandom_range(1, 48);
      else if ($urandom_range(0, 1) == 1) rab = $urandom_range(1, TD * rk);
      else rab = 0;
      rh = 1'($urandom_range(0, 1));
      run(rm, rk, rab, rh);
    end

    // Reset in the middle of a CHASE run: immediate reset values, no done.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_mode = 2'd2; cmd_count = 8'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_led", led, phys(8'h00));
    check("midrst_ready", cmd_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_tick", tick, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_done", done, 1'b0);
      check("postrst_busy", busy, 1'b0);
      check("postrst_tick", tick, 1'b0);
    end
    run(2'd2, 8'd2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
